// File: rtl/rice_core_pkg.sv
// rice_core_pkg
// Shared types for the rice core ALU path.
//   rice_core_alu_command    : ALU function select.
//   rice_core_alu_source_1/2 : operand A (rs1 or pc) and operand B (rs2 or imm).
//   rice_core_alu_operation  : command plus both source selects. An all-zero
//                              value is a harmless ADD rs1+rs2.
//   rice_core_alu_requester  : owner of a shared-ALU slot.
package rice_core_pkg;

    typedef enum logic [3:0] {
        RICE_CORE_ALU_COMMAND_ADD  = 4'd0,
        RICE_CORE_ALU_COMMAND_SUB  = 4'd1,
        RICE_CORE_ALU_COMMAND_SLL  = 4'd2,
        RICE_CORE_ALU_COMMAND_SLT  = 4'd3,
        RICE_CORE_ALU_COMMAND_SLTU = 4'd4,
        RICE_CORE_ALU_COMMAND_XOR  = 4'd5,
        RICE_CORE_ALU_COMMAND_SRL  = 4'd6,
        RICE_CORE_ALU_COMMAND_SRA  = 4'd7,
        RICE_CORE_ALU_COMMAND_OR   = 4'd8,
        RICE_CORE_ALU_COMMAND_AND  = 4'd9
    } rice_core_alu_command;

    typedef enum logic {
        RICE_CORE_ALU_SOURCE_1_RS1 = 1'b0,
        RICE_CORE_ALU_SOURCE_1_PC  = 1'b1
    } rice_core_alu_source_1;

    typedef enum logic {
        RICE_CORE_ALU_SOURCE_2_RS2 = 1'b0,
        RICE_CORE_ALU_SOURCE_2_IMM = 1'b1
    } rice_core_alu_source_2;

    typedef struct packed {
        rice_core_alu_command  command;
        rice_core_alu_source_1 source_1;
        rice_core_alu_source_2 source_2;
    } rice_core_alu_operation;

    typedef enum logic {
        RICE_CORE_ALU_REQUESTER_EXECUTE = 1'b0,
        RICE_CORE_ALU_REQUESTER_ADDRESS = 1'b1
    } rice_core_alu_requester;

    localparam rice_core_alu_operation RICE_CORE_ALU_OPERATION_NONE = '0;

endpackage

// File: rtl/rice_core_alu.sv
// rice_core_alu
// Purely combinational integer ALU.
// Ports:
//   pc, rs1_value, rs2_value, imm_value : candidate operands (XLEN)
//   operation                           : command and source selects
//   result                              : ALU output (XLEN)
module rice_core_alu
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]        pc,
    input  logic [XLEN-1:0]        rs1_value,
    input  logic [XLEN-1:0]        rs2_value,
    input  logic [XLEN-1:0]        imm_value,
    input  rice_core_alu_operation operation,
    output logic [XLEN-1:0]        result
);

    localparam int SHAMT_WIDTH = $clog2(XLEN);

    logic [XLEN-1:0]        operand_a;
    logic [XLEN-1:0]        operand_b;
    logic [SHAMT_WIDTH-1:0] shamt;

    always_comb begin
        operand_a = (operation.source_1 == RICE_CORE_ALU_SOURCE_1_PC)  ? pc        : rs1_value;
        operand_b = (operation.source_2 == RICE_CORE_ALU_SOURCE_2_IMM) ? imm_value : rs2_value;
        shamt     = operand_b[SHAMT_WIDTH-1:0];
        result    = '0;
        case (operation.command)
            RICE_CORE_ALU_COMMAND_ADD:  result = operand_a + operand_b;
            RICE_CORE_ALU_COMMAND_SUB:  result = operand_a - operand_b;
            RICE_CORE_ALU_COMMAND_SLL:  result = operand_a << shamt;
            RICE_CORE_ALU_COMMAND_SLT:  result = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            RICE_CORE_ALU_COMMAND_SLTU: result = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            RICE_CORE_ALU_COMMAND_XOR:  result = operand_a ^ operand_b;
            RICE_CORE_ALU_COMMAND_SRL:  result = operand_a >> shamt;
            RICE_CORE_ALU_COMMAND_SRA:  result = $unsigned($signed(operand_a) >>> shamt);
            RICE_CORE_ALU_COMMAND_OR:   result = operand_a | operand_b;
            RICE_CORE_ALU_COMMAND_AND:  result = operand_a & operand_b;
            default:                    result = '0;
        endcase
    end

endmodule

// File: rtl/rice_core_alu_scheduler.sv
// rice_core_alu_scheduler
// Shares one rice_core_alu between the execute path (requester 0) and the
// address/branch-target path (requester 1). One result register, tagged with
// its owner, adds one cycle of latency and sustains one op per cycle.
//
// Optional feature: RICE_CORE_ALU_SCHEDULER_ROUND_ROBIN_EN
//   defined     : conflicts alternate via a priority register.
//   not defined : requester 0 always wins a conflict (requester 1 may starve).
//
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_req_valid/o_req_ready: per-requester request handshake
//   i_req_pc/rs1/rs2/imm   : per-requester operands
//   i_req_alu_operation    : per-requester ALU command and sources
//   i_req_tag              : per-requester opaque tag
//   o_rsp_valid/i_rsp_ready: per-owner response handshake (one-hot valid)
//   o_rsp_result, o_rsp_tag: captured result and tag
//
// Handshake: a transfer happens on a rising edge where valid && ready. Request
// ready depends combinationally on valid; a requester holds its payload stable
// while valid and not ready. A response holds all fields stable until its
// owner's i_rsp_ready is high; the non-owner's ready bit is ignored.
module rice_core_alu_scheduler
    import rice_core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [1:0]                     i_req_valid,
    output logic [1:0]                     o_req_ready,
    input  logic [1:0][XLEN-1:0]           i_req_pc,
    input  logic [1:0][XLEN-1:0]           i_req_rs1_value,
    input  logic [1:0][XLEN-1:0]           i_req_rs2_value,
    input  logic [1:0][XLEN-1:0]           i_req_imm_value,
    input  rice_core_alu_operation [1:0]   i_req_alu_operation,
    input  logic [1:0][TAG_WIDTH-1:0]      i_req_tag,
    output logic [1:0]                     o_rsp_valid,
    input  logic [1:0]                     i_rsp_ready,
    output logic [XLEN-1:0]                o_rsp_result,
    output logic [TAG_WIDTH-1:0]           o_rsp_tag
);

    logic                   rsp_valid;
    rice_core_alu_requester rsp_owner;
    logic [XLEN-1:0]        rsp_result;
    logic [TAG_WIDTH-1:0]   rsp_tag;

    logic                   slot_free;
    logic                   grant_valid;
    rice_core_alu_requester grant;
    rice_core_alu_requester conflict_winner;
    logic                   accept;

    logic [XLEN-1:0]        alu_pc;
    logic [XLEN-1:0]        alu_rs1_value;
    logic [XLEN-1:0]        alu_rs2_value;
    logic [XLEN-1:0]        alu_imm_value;
    rice_core_alu_operation alu_operation;
    logic [XLEN-1:0]        alu_result;

`ifdef RICE_CORE_ALU_SCHEDULER_ROUND_ROBIN_EN
    // Requester favoured on the next conflict; flips away from whoever won.
    rice_core_alu_requester rr_priority;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_priority <= RICE_CORE_ALU_REQUESTER_EXECUTE;
        end else if (accept) begin
            rr_priority <= (grant == RICE_CORE_ALU_REQUESTER_EXECUTE) ?
                           RICE_CORE_ALU_REQUESTER_ADDRESS : RICE_CORE_ALU_REQUESTER_EXECUTE;
        end
    end

    assign conflict_winner = rr_priority;
`else
    assign conflict_winner = RICE_CORE_ALU_REQUESTER_EXECUTE;
`endif

    // The slot can take a new op if empty or if its current owner drains it
    // this cycle (drain and reload in one cycle, no bubble).
    assign slot_free = !rsp_valid || i_rsp_ready[rsp_owner];

    always_comb begin
        grant_valid = |i_req_valid;
        grant       = RICE_CORE_ALU_REQUESTER_EXECUTE;
        if (&i_req_valid) begin
            grant = conflict_winner;
        end else if (i_req_valid[1]) begin
            grant = RICE_CORE_ALU_REQUESTER_ADDRESS;
        end
        accept      = slot_free && grant_valid;
        o_req_ready = 2'b00;
        if (accept) begin
            o_req_ready[grant] = 1'b1;
        end

        // Idle ALU sees all-zero inputs so it does not toggle on stale data.
        alu_pc        = '0;
        alu_rs1_value = '0;
        alu_rs2_value = '0;
        alu_imm_value = '0;
        alu_operation = RICE_CORE_ALU_OPERATION_NONE;
        if (grant_valid) begin
            alu_pc        = i_req_pc[grant];
            alu_rs1_value = i_req_rs1_value[grant];
            alu_rs2_value = i_req_rs2_value[grant];
            alu_imm_value = i_req_imm_value[grant];
            alu_operation = i_req_alu_operation[grant];
        end
    end

    rice_core_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .pc        (alu_pc),
        .rs1_value (alu_rs1_value),
        .rs2_value (alu_rs2_value),
        .imm_value (alu_imm_value),
        .operation (alu_operation),
        .result    (alu_result)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid  <= 1'b0;
            rsp_owner  <= RICE_CORE_ALU_REQUESTER_EXECUTE;
            rsp_result <= '0;
            rsp_tag    <= '0;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_owner  <= grant;
            rsp_result <= alu_result;
            rsp_tag    <= i_req_tag[grant];
        end else if (slot_free) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_comb begin
        o_rsp_valid = 2'b00;
        if (rsp_valid) begin
            o_rsp_valid[rsp_owner] = 1'b1;
        end
    end

    assign o_rsp_result = rsp_result;
    assign o_rsp_tag    = rsp_tag;

endmodule
